// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared ALU definitions: the 3-bit IA operation codes produced by ALU
//   control.  Used by ALU control, the combinational ALU and the multi-cycle
//   multiply/divide sequencer.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] IA_ADD  = 3'b000;
  localparam logic [2:0] IA_SUB  = 3'b001;
  localparam logic [2:0] IA_MULT = 3'b010;
  localparam logic [2:0] IA_DIV  = 3'b011;
  localparam logic [2:0] IA_AND  = 3'b100;
  localparam logic [2:0] IA_OR   = 3'b101;
  localparam logic [2:0] IA_XOR  = 3'b110;
  localparam logic [2:0] IA_NOP  = 3'b111;

endpackage

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle sequencer for the ALU's MULT and DIV operations.  An unsigned
//   shift-add multiply or restoring divide runs one bit per clock; a stall
//   holds the front of the pipeline while the operation is in flight and the
//   2*WIDTH result is returned split into hi/lo halves.
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous, active-high reset
//     start        request qualifier for the current instruction
//     ia           ALU op code (010 = MULT, 011 = DIV; others ignored)
//     op_a         multiplicand / dividend
//     op_b         multiplier / divisor
//     busy         operation in progress (registered)
//     stall        busy | accept (combinational)
//     done         one-cycle pulse; results valid from this cycle
//     result_lo    MULT: low product half;  DIV: quotient
//     result_hi    MULT: high product half; DIV: remainder
//     div_by_zero  set with done when a DIV had op_b == 0
// ---------------------------------------------------------------------------
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ia,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   res_lo_q;
  logic [WIDTH-1:0]   res_hi_q;

  // Working accumulator: hi holds partial product / remainder, lo holds the
  // multiplier being consumed / dividend being shifted out and quotient in.
  logic [WIDTH-1:0]   hi_q, lo_q, b_q;
  logic [WIDTH-1:0]   hi_d, lo_d;

  logic               accept;
  logic               is_mul_op, is_div_op;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     add_a, add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_full;
  logic               div_ge;

  assign is_mul_op = (ia == IA_MULT);
  assign is_div_op = (ia == IA_DIV);
  assign accept    = start & (state_q == S_IDLE) & (is_mul_op | is_div_op);

  assign busy        = busy_q;
  assign stall       = busy_q | accept;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

  // One (WIDTH+1)-bit adder shared by both operations.  MUL adds b to hi when
  // the current multiplier bit is set; DIV subtracts b from the shifted
  // remainder via two's complement, and the carry-out doubles as rem >= b.
  always_comb begin
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_DIV) begin
      add_a   = rem_sh;
      add_b   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, b_q} : '0;
    end
    add_full = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    div_ge   = add_full[WIDTH+1];

    if (state_q == S_DIV) begin
      hi_d = div_ge ? add_full[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      // {carry, hi, lo} shifted right by one
      hi_d = add_full[WIDTH:1];
      lo_d = {add_full[0], lo_q[WIDTH-1:1]};
    end
  end

  // Working registers carry no reset: they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_q <= '0;
      lo_q <= op_a;
      b_q  <= op_b;
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Control FSM with registered outputs.  The final iteration is folded into
  // the result registers on entry to DONE, so partial values never appear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            dbz_q  <= 1'b0;
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH - 1);
            if (is_mul_op) begin
              state_q <= S_MUL;
            end else if (op_b == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              dbz_q    <= 1'b1;
              res_lo_q <= '1;
              res_hi_q <= op_a;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            res_hi_q <= hi_d;
            res_lo_q <= lo_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
